// File: rtl/pecwei_loader.sv
// Purpose : double-buffered (ping-pong) weight store for one PE cluster; requests and loads
//           NUM_WEI-word weight sets while the compute core reads the other bank.
// Latency : read data registered, valid one cycle after PEC_RdAddr; WeiRdy one cycle after DONE.
// Backpressure: beats accepted only while CTRLWEIPEC_RdyWei && DISWEIPEC_ValWei in LOAD; RdyWei low pauses the load.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   PECCTRLWEI_GetWei        out  one-cycle request for a weight set
//   CTRLWEIPEC_RdyWei        in   level grant of the weight bus
//   DISWEIPEC_Wei/_ValWei    in   weight word and its valid
//   PEC_SwitchBank           in   compute core releases its bank
//   PEC_RdAddr               in   read word index into the compute bank
//   PECWEI_RdWei             out  registered read data (0 for out-of-range index)
//   PECWEI_WeiRdy            out  compute bank holds a complete set
//   PECWEI_ErrWei            out  sticky dropped-beat flag
//
// Build option: define PECWEI_ERR_CHK_EN to build the dropped-beat checker;
// otherwise PECWEI_ErrWei is tied low.

module pecwei_loader #(
    parameter int WEI_WIDTH  = 8,
    parameter int NUM_WEI    = 27,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  PECCTRLWEI_GetWei,
    input  logic                  CTRLWEIPEC_RdyWei,
    input  logic [WEI_WIDTH-1:0]  DISWEIPEC_Wei,
    input  logic                  DISWEIPEC_ValWei,
    input  logic                  PEC_SwitchBank,
    input  logic [ADDR_WIDTH-1:0] PEC_RdAddr,
    output logic [WEI_WIDTH-1:0]  PECWEI_RdWei,
    output logic                  PECWEI_WeiRdy,
    output logic                  PECWEI_ErrWei
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_WEI - 1);
    // one extra bit so the range compare works even when NUM_WEI == 2**ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0]   NUM_WEI_EXT = (ADDR_WIDTH + 1)'(NUM_WEI);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [1:0]              full;
    logic [1:0]              full_nxt;
    logic                    accept;
    logic                    switch_ok;
    logic                    get_wei;
    logic [WEI_WIDTH-1:0]    rd_dat;

    logic [WEI_WIDTH-1:0]    mem [2][NUM_WEI];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        get_wei   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // both banks full: wait until compute releases one
                if (!full[wr_bank]) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                get_wei   = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                accept = CTRLWEIPEC_RdyWei & DISWEIPEC_ValWei;
                if (accept && (cnt == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign PECCTRLWEI_GetWei = get_wei;

    // ------------------------------------------------------------------
    // Load counter and bank pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == DONE) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
        end else if (state == DONE) begin
            wr_bank <= ~wr_bank;
        end
    end

    assign switch_ok = PEC_SwitchBank & full[rd_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank <= 1'b0;
        end else if (switch_ok) begin
            rd_bank <= ~rd_bank;
        end
    end

    // A DONE set and a release clear can land together; they never hit the
    // same bank because a bank is only loaded while its full bit is clear.
    always_comb begin
        full_nxt = full;
        if (state == DONE) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (switch_ok) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    assign PECWEI_WeiRdy = full[rd_bank];

    // ------------------------------------------------------------------
    // Storage: write port from the load path, registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][cnt] <= DISWEIPEC_Wei;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dat <= '0;
        end else if ({1'b0, PEC_RdAddr} < NUM_WEI_EXT) begin
            rd_dat <= mem[rd_bank][PEC_RdAddr];
        end else begin
            rd_dat <= '0;
        end
    end

    assign PECWEI_RdWei = rd_dat;

    // ------------------------------------------------------------------
    // Dropped-beat checker
    // ------------------------------------------------------------------
`ifdef PECWEI_ERR_CHK_EN
    logic err;
    logic drop;

    // any valid beat that the load path did not take is a protocol error
    assign drop = DISWEIPEC_ValWei & ~accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end

    assign PECWEI_ErrWei = err;
`else
    assign PECWEI_ErrWei = 1'b0;
`endif

endmodule

// File: tb/tb_pecwei_loader.sv
// Directed bench for pecwei_loader: reset, ping-pong load, pause, error flag,
// bank switching and reset during a load.
module tb_pecwei_loader;

    logic       clk;
    logic       rst;
    logic       get_wei;
    logic       rdy;
    logic [7:0] wei;
    logic       val;
    logic       sw;
    logic [4:0] rd_addr;
    logic [7:0] rd_wei;
    logic       wei_rdy;
    logic       err_wei;

    int n_checks;
    int n_pass;

`ifdef PECWEI_ERR_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    pecwei_loader #(
        .WEI_WIDTH (8),
        .NUM_WEI   (27),
        .ADDR_WIDTH(5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .PECCTRLWEI_GetWei(get_wei),
        .CTRLWEIPEC_RdyWei(rdy),
        .DISWEIPEC_Wei    (wei),
        .DISWEIPEC_ValWei (val),
        .PEC_SwitchBank   (sw),
        .PEC_RdAddr       (rd_addr),
        .PECWEI_RdWei     (rd_wei),
        .PECWEI_WeiRdy    (wei_rdy),
        .PECWEI_ErrWei    (err_wei)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wei = 8'(base + i);
            val = 1'b1;
            tick();
        end
        val = 1'b0;
        wei = 8'h00;
    endtask

    task automatic test_reset();
        int gets;
        rst = 1'b1; rdy = 1'b0; val = 1'b0; wei = 8'h00; sw = 1'b0; rd_addr = 5'd0;
        tick(); tick();
        n_checks++; if (get_wei !== 1'b0) $display("FAIL rst_get: got %0b want 0", get_wei); else n_pass++;
        n_checks++; if (rd_wei !== 8'h00) $display("FAIL rst_rdwei: got %0h want 0", rd_wei); else n_pass++;
        n_checks++; if (wei_rdy !== 1'b0) $display("FAIL rst_weirdy: got %0b want 0", wei_rdy); else n_pass++;
        n_checks++; if (err_wei !== 1'b0) $display("FAIL rst_err: got %0b want 0", err_wei); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (get_wei !== 1'b1) $display("FAIL first_get: got %0b want 1", get_wei); else n_pass++;
        gets = (get_wei === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (get_wei === 1'b1) gets++;
        end
        n_checks++; if (gets !== 1) $display("FAIL get_once: got %0d pulses want 1", gets); else n_pass++;
        n_checks++; if (wei_rdy !== 1'b0) $display("FAIL idle_weirdy: got %0b want 0", wei_rdy); else n_pass++;
    endtask

    task automatic test_load_bank0();
        rdy = 1'b1;
        send_beats(1, 27);
        n_checks++; if (wei_rdy !== 1'b0) $display("FAIL done_weirdy: got %0b want 0", wei_rdy); else n_pass++;
        tick();
        n_checks++; if (wei_rdy !== 1'b1) $display("FAIL load0_weirdy: got %0b want 1", wei_rdy); else n_pass++;
        tick();
        n_checks++; if (get_wei !== 1'b1) $display("FAIL bank1_get: got %0b want 1", get_wei); else n_pass++;
        rd_addr = 5'd5;  tick();
        n_checks++; if (rd_wei !== 8'd6) $display("FAIL rd5: got %0d want 6", rd_wei); else n_pass++;
        rd_addr = 5'd26; tick();
        n_checks++; if (rd_wei !== 8'd27) $display("FAIL rd26: got %0d want 27", rd_wei); else n_pass++;
        rd_addr = 5'd0;  tick();
        n_checks++; if (rd_wei !== 8'd1) $display("FAIL rd0: got %0d want 1", rd_wei); else n_pass++;
    endtask

    task automatic test_pause();
        int gets;
        gets = 0;
        send_beats(101, 10);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (get_wei === 1'b1) gets++;
        end
        n_checks++; if (gets !== 0) $display("FAIL pause_get: got %0d pulses want 0", gets); else n_pass++;
        rdy = 1'b1;
        send_beats(111, 17);
        gets = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (get_wei === 1'b1) gets++;
        end
        n_checks++; if (gets !== 0) $display("FAIL both_full_get: got %0d pulses want 0", gets); else n_pass++;
        n_checks++; if (wei_rdy !== 1'b1) $display("FAIL pause_weirdy: got %0b want 1", wei_rdy); else n_pass++;
    endtask

    task automatic test_err();
        n_checks++; if (err_wei !== 1'b0) $display("FAIL err_pre: got %0b want 0", err_wei); else n_pass++;
        rdy = 1'b1; val = 1'b1; wei = 8'hEE;
        tick();
        val = 1'b0; wei = 8'h00;
        n_checks++; if (err_wei !== ERR_EXP) $display("FAIL err_set: got %0b want %0b", err_wei, ERR_EXP); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (err_wei !== ERR_EXP) $display("FAIL err_sticky: got %0b want %0b", err_wei, ERR_EXP); else n_pass++;
        rd_addr = 5'd3; tick();
        n_checks++; if (rd_wei !== 8'd4) $display("FAIL err_rd3: got %0d want 4", rd_wei); else n_pass++;
    endtask

    task automatic test_switch();
        n_checks++; if (wei_rdy !== 1'b1) $display("FAIL sw_pre_weirdy: got %0b want 1", wei_rdy); else n_pass++;
        rdy = 1'b0;
        sw = 1'b1; tick(); sw = 1'b0;
        n_checks++; if (wei_rdy !== 1'b1) $display("FAIL sw1_weirdy: got %0b want 1", wei_rdy); else n_pass++;
        rd_addr = 5'd10; tick();
        n_checks++; if (get_wei !== 1'b1) $display("FAIL sw1_get: got %0b want 1", get_wei); else n_pass++;
        n_checks++; if (rd_wei !== 8'd111) $display("FAIL b1_rd10: got %0d want 111", rd_wei); else n_pass++;
        rd_addr = 5'd26; tick();
        n_checks++; if (rd_wei !== 8'd127) $display("FAIL b1_rd26: got %0d want 127", rd_wei); else n_pass++;
        // valid beats while the grant is low must be dropped
        val = 1'b1; wei = 8'hEE;
        tick(); tick(); tick();
        val = 1'b0; wei = 8'h00;
        sw = 1'b1; tick(); sw = 1'b0;
        n_checks++; if (wei_rdy !== 1'b0) $display("FAIL sw2_weirdy: got %0b want 0", wei_rdy); else n_pass++;
        sw = 1'b1; tick(); sw = 1'b0;
        n_checks++; if (wei_rdy !== 1'b0) $display("FAIL sw3_weirdy: got %0b want 0", wei_rdy); else n_pass++;
        rdy = 1'b1;
        send_beats(201, 27);
        tick();
        n_checks++; if (wei_rdy !== 1'b1) $display("FAIL reload0_weirdy: got %0b want 1", wei_rdy); else n_pass++;
        rd_addr = 5'd5; tick();
        n_checks++; if (rd_wei !== 8'd206) $display("FAIL b0_rd5: got %0d want 206", rd_wei); else n_pass++;
        n_checks++; if (get_wei !== 1'b1) $display("FAIL reload1_get: got %0b want 1", get_wei); else n_pass++;
        rd_addr = 5'd26; tick();
        n_checks++; if (rd_wei !== 8'd227) $display("FAIL b0_rd26: got %0d want 227", rd_wei); else n_pass++;
    endtask

    task automatic test_reset_midload();
        rdy = 1'b1;
        send_beats(31, 15);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (get_wei !== 1'b0) $display("FAIL mid_rst_get: got %0b want 0", get_wei); else n_pass++;
        n_checks++; if (rd_wei !== 8'h00) $display("FAIL mid_rst_rdwei: got %0h want 0", rd_wei); else n_pass++;
        n_checks++; if (wei_rdy !== 1'b0) $display("FAIL mid_rst_weirdy: got %0b want 0", wei_rdy); else n_pass++;
        n_checks++; if (err_wei !== 1'b0) $display("FAIL mid_rst_err: got %0b want 0", err_wei); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        n_checks++; if (get_wei !== 1'b1) $display("FAIL post_rst_get: got %0b want 1", get_wei); else n_pass++;
        tick();
        send_beats(51, 27);
        tick();
        n_checks++; if (wei_rdy !== 1'b1) $display("FAIL post_rst_weirdy: got %0b want 1", wei_rdy); else n_pass++;
        n_checks++; if (err_wei !== 1'b0) $display("FAIL post_rst_err: got %0b want 0", err_wei); else n_pass++;
        rd_addr = 5'd30; tick();
        n_checks++; if (rd_wei !== 8'h00) $display("FAIL rd30: got %0d want 0", rd_wei); else n_pass++;
        rd_addr = 5'd14; tick();
        n_checks++; if (rd_wei !== 8'd65) $display("FAIL post_rst_rd14: got %0d want 65", rd_wei); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; rdy = 1'b0; val = 1'b0; wei = 8'h00; sw = 1'b0; rd_addr = 5'd0;
        test_reset();
        test_load_bank0();
        test_pause();
        test_err();
        test_switch();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
